// File: rtl/photodiode_pkg.sv
// Shared register map and field layout for the photodiode beam sensor.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package photodiode_pkg;

   // Avalon word offsets
   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_EVENTS = 2'd1;
   localparam logic [1:0] REG_MASK   = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;

   // EVENTS / MASK field positions; each field is 16 bits wide so up to
   // 16 beams fit without the BROKEN and RESTORED fields overlapping.
   localparam int BROKEN_LSB   = 0;
   localparam int RESTORED_LSB = 16;

   // Number of set bits in a 16-bit vector (beams breaking in one cycle).
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/pd_debounce.sv
// One photodiode channel: 2-FF synchroniser, polarity fix, hold-time debouncer.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES cycles from raw change to stable_o.
// Backpressure: none; the raw level is sampled every cycle.
module pd_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             beam_b;

   // Bring the asynchronous photodiode level into the clk domain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
      end
   end

   // 1 = beam broken, independent of the photodiode wiring polarity.
   assign beam_b = ACTIVE_LOW ? ~sync_q : sync_q;

   // Accept a new level only after it has differed from stable for the full hold time.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (beam_b == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = beam_b;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Debounce state register; reset forgets any partially counted change.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/photodiode_beam_sensor.sv
// Laser-harp photodiode Avalon-MM slave: debounced beams, latched edge events, maskable irq.
// Latency: readdata 1 cycle after avs_read; event bit 1 cycle after stable edge; irq 1 cycle after event.
// Backpressure: none; the slave accepts every read/write in the cycle it is presented.
module photodiode_beam_sensor #(
   parameter int NUM_BEAMS       = 8,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NUM_BEAMS-1:0] pd_in,
   input  logic [1:0]           avs_address,
   input  logic                 avs_read,
   output logic [31:0]          avs_readdata,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic                 irq
);

   import photodiode_pkg::*;

   logic [NUM_BEAMS-1:0] stable_w;
   logic [NUM_BEAMS-1:0] prev_q;
   logic [NUM_BEAMS-1:0] broken_evt, restored_evt;
   logic [NUM_BEAMS-1:0] brk_q, brk_d, rst_q, rst_d;
   logic [NUM_BEAMS-1:0] mbrk_q, mbrk_d, mrst_q, mrst_d;
   logic [15:0]          count_q, count_d;
   logic [31:0]          rd_mux;
   logic [31:0]          rdata_q, rdata_d;
   logic                 irq_q, irq_d;
   logic                 wr_events, wr_mask, wr_count;
   logic                 unused_wdata;

   for (genvar g = 0; g < NUM_BEAMS; g++) begin : g_beam
      pd_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_deb (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw_i    (pd_in[g]),
         .stable_o (stable_w[g])
      );
   end

   assign broken_evt   =  stable_w & ~prev_q;
   assign restored_evt = ~stable_w &  prev_q;

   assign wr_events = avs_write && (avs_address == REG_EVENTS);
   assign wr_mask   = avs_write && (avs_address == REG_MASK);
   assign wr_count  = avs_write && (avs_address == REG_COUNT);

   // Only the low NUM_BEAMS bits of each field carry state.
   assign unused_wdata = ^avs_writedata;

   // Read mux over the pre-write register values; unused bits read as zero.
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         REG_STATUS: rd_mux[NUM_BEAMS-1:0] = stable_w;
         REG_EVENTS: begin
            rd_mux[BROKEN_LSB   +: NUM_BEAMS] = brk_q;
            rd_mux[RESTORED_LSB +: NUM_BEAMS] = rst_q;
         end
         REG_MASK: begin
            rd_mux[BROKEN_LSB   +: NUM_BEAMS] = mbrk_q;
            rd_mux[RESTORED_LSB +: NUM_BEAMS] = mrst_q;
         end
         REG_COUNT:  rd_mux[15:0] = count_q;
         default:    rd_mux = '0;
      endcase
   end

   // Register next-state: W1C clears lose to same-cycle events, count write then adds new breaks.
   always_comb begin
      brk_d   = brk_q;
      rst_d   = rst_q;
      mbrk_d  = mbrk_q;
      mrst_d  = mrst_q;
      count_d = count_q;
      rdata_d = rdata_q;
      if (wr_events) begin
         brk_d = brk_q & ~avs_writedata[BROKEN_LSB   +: NUM_BEAMS];
         rst_d = rst_q & ~avs_writedata[RESTORED_LSB +: NUM_BEAMS];
      end
      brk_d = brk_d | broken_evt;
      rst_d = rst_d | restored_evt;
      if (wr_mask) begin
         mbrk_d = avs_writedata[BROKEN_LSB   +: NUM_BEAMS];
         mrst_d = avs_writedata[RESTORED_LSB +: NUM_BEAMS];
      end
      count_d = (wr_count ? 16'h0000 : count_q) + {11'b0, popcount16(16'(broken_evt))};
      if (avs_read) begin
         rdata_d = rd_mux;
      end
      irq_d = |((brk_q & mbrk_q) | (rst_q & mrst_q));
   end

   // All architectural state, cleared together by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_q  <= '0;
         brk_q   <= '0;
         rst_q   <= '0;
         mbrk_q  <= '0;
         mrst_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         prev_q  <= stable_w;
         brk_q   <= brk_d;
         rst_q   <= rst_d;
         mbrk_q  <= mbrk_d;
         mrst_q  <= mrst_d;
         count_q <= count_d;
         rdata_q <= rdata_d;
         irq_q   <= irq_d;
      end
   end

   assign avs_readdata = rdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_photodiode_beam_sensor.sv
// Bench for photodiode_beam_sensor: directed vectors, read scoreboard, irq level checks.
// Two instances: main (hold time 16, active-low) and fast (hold time 1, active-high) for COUNT wrap.
// Reads push expected data; a monitor pops and compares the cycle after each read strobe.
`timescale 1ns/1ps
module tb_photodiode_beam_sensor;
   import photodiode_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  pd_in, pd_f;
   logic [1:0]  avs_address, addr_f;
   logic        avs_read, rd_f, avs_write, wr_f;
   logic [31:0] avs_writedata, wdata_f;
   logic [31:0] avs_readdata, rdata_f;
   logic        irq, irq_f;

   typedef struct {
      string       name;
      bit          sel;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       checks = 0;
   int       errors = 0;
   logic     rd_fire_q = 1'b0;
   logic     rd_sel_q  = 1'b0;

   always #5 clk = ~clk;

   photodiode_beam_sensor #(
      .NUM_BEAMS(8), .DEBOUNCE_CYCLES(16), .CNT_W(16), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pd_in(pd_in),
      .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
      .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
   );

   photodiode_beam_sensor #(
      .NUM_BEAMS(8), .DEBOUNCE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b0)
   ) dut_fast (
      .clk(clk), .reset_n(reset_n), .pd_in(pd_f),
      .avs_address(addr_f), .avs_read(rd_f), .avs_readdata(rdata_f),
      .avs_write(wr_f), .avs_writedata(wdata_f), .irq(irq_f)
   );

   // Remember which instance was read at each edge.
   always @(posedge clk) begin
      rd_fire_q <= avs_read | rd_f;
      rd_sel_q  <= rd_f;
   end

   // Monitor: compare registered readdata against the oldest expected entry.
   always @(negedge clk) begin
      if (rd_fire_q) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: no expected entry, readdata=%08h", avs_readdata);
         end else begin
            sb_item_t it;
            logic [31:0] act;
            it  = sb_q.pop_front();
            act = it.sel ? rdata_f : avs_readdata;
            if (act !== it.exp) begin
               errors++;
               $display("FAIL %s: got %08h expected %08h", it.name, act, it.exp);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_read(input bit f, input logic [1:0] a, input logic [31:0] exp, input string name);
      sb_item_t it;
      it.name = name;
      it.sel  = f;
      it.exp  = exp;
      sb_q.push_back(it);
      if (f) begin addr_f = a; rd_f = 1'b1; end
      else   begin avs_address = a; avs_read = 1'b1; end
      tick();
      rd_f     = 1'b0;
      avs_read = 1'b0;
   endtask

   task automatic bus_write(input bit f, input logic [1:0] a, input logic [31:0] d);
      if (f) begin addr_f = a; wdata_f = d; wr_f = 1'b1; end
      else   begin avs_address = a; avs_writedata = d; avs_write = 1'b1; end
      tick();
      wr_f      = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic check_val(input logic [31:0] act, input logic [31:0] exp, input string name);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Break-and-restore every fast beam once: 8 BROKEN events per call.
   task automatic fast_pulse();
      pd_f = 8'hFF;
      tick(2);
      pd_f = 8'h00;
      tick(2);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d expected 0", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      pd_in = 8'hFF; pd_f = 8'h00;
      avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0;
      addr_f = '0; rd_f = 0; wr_f = 0; wdata_f = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val(avs_readdata, 32'h0, "reset_readdata");
      check_val({31'b0, irq}, 32'h0, "reset_irq");
      reset_n = 1'b1;
      tick(25);
      bus_read(0, REG_STATUS, 32'h0, "rst_status");
      bus_read(0, REG_EVENTS, 32'h0, "rst_events");
      bus_read(0, REG_MASK,   32'h0, "rst_mask");
      bus_read(0, REG_COUNT,  32'h0, "rst_count");
      bus_read(1, REG_COUNT,  32'h0, "fast_rst_count");
      check_val({31'b0, irq}, 32'h0, "rst_irq_after");

      // Clean break of beam 3: stable updates on the 18th edge after the change.
      pd_in[3] = 1'b0;
      tick(17);
      bus_read(0, REG_STATUS, 32'h0,  "break_status_edge18");
      bus_read(0, REG_STATUS, 32'h08, "break_status_edge19");
      bus_read(0, REG_EVENTS, 32'h08, "break_events");
      bus_read(0, REG_COUNT,  32'h1,  "break_count");
      tick(20);

      // Glitch on beam 0 shorter than the hold time.
      pd_in[0] = 1'b0;
      tick(10);
      pd_in[0] = 1'b1;
      tick(30);
      bus_read(0, REG_STATUS, 32'h08, "glitch_status");
      bus_read(0, REG_EVENTS, 32'h08, "glitch_events");
      bus_read(0, REG_COUNT,  32'h1,  "glitch_count");

      // Restore beam 3, clear everything, arm BROKEN[3].
      pd_in[3] = 1'b1;
      tick(25);
      bus_read(0, REG_EVENTS, 32'h00080008, "restore_events");
      bus_write(0, REG_EVENTS, 32'hFFFFFFFF);
      bus_read(0, REG_EVENTS, 32'h0, "w1c_all");
      bus_write(0, REG_MASK, 32'h00000008);
      bus_read(0, REG_MASK, 32'h00000008, "mask_rb");

      // irq timing: event sets at edge 19, irq at edge 20.
      pd_in[3] = 1'b0;
      tick(19);
      check_val({31'b0, irq}, 32'h0, "irq_before");
      tick();
      check_val({31'b0, irq}, 32'h1, "irq_asserted");
      bus_write(0, REG_EVENTS, 32'h00000008);
      check_val({31'b0, irq}, 32'h1, "irq_hold_after_w1c");
      tick();
      check_val({31'b0, irq}, 32'h0, "irq_cleared");
      pd_in[3] = 1'b1;
      tick(25);
      bus_read(0, REG_EVENTS, 32'h00080000, "restore_masked_events");
      check_val({31'b0, irq}, 32'h0, "irq_restore_masked");
      bus_read(0, REG_COUNT, 32'h2, "count_two");

      // Race: W1C of BROKEN[5] lands on the same edge beam 5 re-breaks.
      pd_in[5] = 1'b0;
      tick(25);
      pd_in[5] = 1'b1;
      tick(25);
      bus_read(0, REG_EVENTS, 32'h00280020, "pre_race_events");
      pd_in[5] = 1'b0;
      tick(18);
      bus_write(0, REG_EVENTS, 32'h00000020);
      tick(2);
      bus_read(0, REG_EVENTS, 32'h00280020, "race_set_wins");

      // COUNT write on the same edge as beam 6 breaks.
      pd_in[6] = 1'b0;
      tick(18);
      bus_write(0, REG_COUNT, 32'h0);
      tick(2);
      bus_read(0, REG_COUNT, 32'h1, "count_write_race");

      // Beams 1 and 2 break together.
      pd_in[2:1] = 2'b00;
      tick(25);
      bus_read(0, REG_COUNT,  32'h3,  "popcount_two");
      bus_read(0, REG_STATUS, 32'h66, "status_multi");

      // Read and W1C in the same cycle: readdata shows the pre-write value.
      begin
         sb_item_t it;
         it.name = "rw_same_cycle";
         it.sel  = 1'b0;
         it.exp  = 32'h00280066;
         sb_q.push_back(it);
         avs_address = REG_EVENTS; avs_read = 1'b1; avs_write = 1'b1; avs_writedata = 32'hFFFFFFFF;
         tick();
         avs_read = 1'b0; avs_write = 1'b0;
      end
      bus_read(0, REG_EVENTS, 32'h0, "rw_after_clear");

      // Unused mask bits read as zero; RESTORED enable raises irq.
      bus_write(0, REG_MASK, 32'hFFFFFFFF);
      bus_read(0, REG_MASK, 32'h00FF00FF, "mask_unused_bits");
      pd_in[1] = 1'b1;
      tick(25);
      check_val({31'b0, irq}, 32'h1, "irq_restored_enabled");

      // COUNT wrap on the fast instance: 8191 pulses = 0xFFF8, one more wraps to 0.
      for (int i = 0; i < 8191; i++) fast_pulse();
      tick(8);
      bus_read(1, REG_COUNT, 32'h0000FFF8, "fast_count_pre_wrap");
      fast_pulse();
      tick(8);
      bus_read(1, REG_COUNT,  32'h0, "fast_count_wrap");
      bus_read(1, REG_STATUS, 32'h0, "fast_status");

      tick(3);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
